rumble_scheduler: RTL and testbench

- Shares a single rumble/LED-motor drive budget among NUM_PLAYERS controllers. Only one motor may be energised at any time.
- Each player's CPU raises an MMIO strobe with a pulse count. The block queues one request per player and grants pending requests round-robin.
- It then plays a timed on/off pulse train on the granted player's motor output.
- It replaces the per-controller free-running LED pattern counters and sits between the MMIO output words and the motor pins.

---
 rtl/rumble_scheduler.sv | 118 +++++++++++
 tb/tb_rumble_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rumble_scheduler.sv
// rumble_scheduler: round-robin sharing of one rumble motor budget among NUM_PLAYERS controllers.
// Ports: fastClock/reset (async, active-high); reqStrobe/reqPulses per-player request strobe and 3-bit pulse count;
// motorOut one-hot-or-zero drive; busy while not idle; activePlayer last served index; pending queued-request flags.
module rumble_scheduler #(
  parameter int NUM_PLAYERS = 2,
  parameter int IDX_W       = 1,
  parameter int ON_CYCLES   = 2000000,
  parameter int OFF_CYCLES  = 2000000,
  parameter int TIMER_W     = 32
) (
  input  logic                     fastClock,
  input  logic                     reset,
  input  logic [NUM_PLAYERS-1:0]   reqStrobe,
  input  logic [3*NUM_PLAYERS-1:0] reqPulses,
  output logic [NUM_PLAYERS-1:0]   motorOut,
  output logic                     busy,
  output logic [IDX_W-1:0]         activePlayer,
  output logic [NUM_PLAYERS-1:0]   pending
);
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;
  localparam logic [TIMER_W-1:0] ON_LD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LD = TIMER_W'(OFF_CYCLES - 1);
  state_t                   state_q, state_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic [2:0]               rem_q, rem_d, gcnt;
  logic [3*NUM_PLAYERS-1:0] cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0]   pend_q, pend_d, hist_q, motor_q, motor_d, rise;
  logic [IDX_W-1:0]         ptr_q, ptr_d, act_q, act_d, g;
  logic                     found, grant;
  always_comb begin
    rise = reqStrobe & ~hist_q;
    g = '0;
    gcnt = '0;
    found = 1'b0;
    // first pending at or after the pointer, then wrap to the lowest index
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (!found && pend_q[p] && p >= int'(ptr_q)) begin
        g = IDX_W'(p);
        gcnt = cnt_q[3*p +: 3];
        found = 1'b1;
      end
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (!found && pend_q[p]) begin
        g = IDX_W'(p);
        gcnt = cnt_q[3*p +: 3];
        found = 1'b1;
      end
    state_d = state_q;
    timer_d = timer_q;
    rem_d = rem_q;
    motor_d = motor_q;
    act_d = act_q;
    ptr_d = ptr_q;
    pend_d = pend_q;
    cnt_d = cnt_q;
    grant = 1'b0;
    case (state_q)
      S_IDLE: grant = found;
      S_ON:
        if (timer_q == '0) begin
          state_d = S_OFF;
          motor_d = '0;
          timer_d = OFF_LD;
          rem_d = rem_q - 3'd1;
        end else timer_d = timer_q - TIMER_W'(1);
      S_OFF:
        if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
        else if (rem_q != '0) begin
          state_d = S_ON;
          motor_d = NUM_PLAYERS'(1) << act_q;
          timer_d = ON_LD;
        end else if (found) grant = 1'b1;
        else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (grant) begin
      state_d = S_ON;
      motor_d = NUM_PLAYERS'(1) << g;
      act_d = g;
      rem_d = gcnt;
      pend_d = pend_q & ~(NUM_PLAYERS'(1) << g);
      timer_d = ON_LD;
      ptr_d = (g == IDX_W'(NUM_PLAYERS - 1)) ? '0 : g + IDX_W'(1);
    end
    // applied after the grant clear so a rise on the granting edge re-queues that player
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (rise[p] && reqPulses[3*p +: 3] != 3'd0) begin
        pend_d[p] = 1'b1;
        cnt_d[3*p +: 3] = reqPulses[3*p +: 3];
      end
  end
  always_ff @(posedge fastClock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      hist_q <= '0;
      motor_q <= '0;
      ptr_q <= '0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      hist_q <= reqStrobe;
      motor_q <= motor_d;
      ptr_q <= ptr_d;
      act_q <= act_d;
    end
  assign busy = state_q != S_IDLE;
  assign motorOut = motor_q;
  assign activePlayer = act_q;
  assign pending = pend_q;
endmodule

// File: tb/tb_rumble_scheduler.sv
// tb_rumble_scheduler: directed checks of rumble_scheduler with ON=4, OFF=3, two players.
module tb_rumble_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] reqStrobe = '0;
  logic [5:0] reqPulses = '0;
  logic [1:0] motorOut;
  logic       busy;
  logic [0:0] activePlayer;
  logic [1:0] pending;
  int checks = 0;
  int failures = 0;
  rumble_scheduler #(
    .NUM_PLAYERS(2), .IDX_W(1), .ON_CYCLES(4), .OFF_CYCLES(3), .TIMER_W(8)
  ) dut (
    .fastClock(clk), .reset(rst), .reqStrobe(reqStrobe), .reqPulses(reqPulses),
    .motorOut(motorOut), .busy(busy), .activePlayer(activePlayer), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    rst = 1'b1;
    reqStrobe = '0;
    reqPulses = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (motorOut !== 2'b00 || busy !== 1'b0 || activePlayer !== 1'b0 || pending !== 2'b00) begin
      failures++;
      $display("FAIL reset_state got motor=%b busy=%b act=%b pend=%b exp 00/0/0/00", motorOut, busy, activePlayer, pending);
    end
  endtask
  task automatic test_single();
    logic [1:0] em;
    logic eb;
    do_reset();
    reqStrobe = 2'b01;
    reqPulses = 6'o02;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) reqStrobe = '0;
      em = (k >= 2 && k - 2 < 14 && (k - 2) % 7 < 4) ? 2'b01 : 2'b00;
      eb = k >= 2 && k <= 15;
      checks++;
      if (motorOut !== em) begin
        failures++;
        $display("FAIL single_motor k=%0d got=%b exp=%b", k, motorOut, em);
      end
      checks++;
      if (busy !== eb) begin
        failures++;
        $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, eb);
      end
      if (k <= 2) begin
        checks++;
        if (pending !== (k == 1 ? 2'b01 : 2'b00)) begin
          failures++;
          $display("FAIL single_pending k=%0d got=%b", k, pending);
        end
      end
    end
  endtask
  task automatic test_both();
    logic [1:0] em;
    do_reset();
    reqStrobe = 2'b11;
    reqPulses = 6'o11;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) reqStrobe = '0;
      em = (k >= 2 && k <= 5) ? 2'b01 : (k >= 9 && k <= 12) ? 2'b10 : 2'b00;
      checks++;
      if (motorOut !== em) begin
        failures++;
        $display("FAIL both_motor k=%0d got=%b exp=%b", k, motorOut, em);
      end
      if (k == 9) begin
        checks++;
        if (activePlayer !== 1'b1) begin
          failures++;
          $display("FAIL both_active got=%b exp=1", activePlayer);
        end
      end
    end
  endtask
  task automatic test_rotation();
    reqStrobe = 2'b11;
    reqPulses = 6'o11;
    @(negedge clk);
    reqStrobe = '0;
    @(negedge clk);
    checks++;
    if (motorOut !== 2'b01 || activePlayer !== 1'b0) begin
      failures++;
      $display("FAIL rot_p1_last got motor=%b act=%b exp 01/0", motorOut, activePlayer);
    end
    repeat (14) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rot_idle1 got busy=%b exp=0", busy);
    end
    do_reset();
    reqStrobe = 2'b01;
    reqPulses = 6'o01;
    @(negedge clk);
    reqStrobe = '0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rot_idle2 got busy=%b exp=0", busy);
    end
    reqStrobe = 2'b11;
    reqPulses = 6'o11;
    @(negedge clk);
    reqStrobe = '0;
    @(negedge clk);
    checks++;
    if (motorOut !== 2'b10 || activePlayer !== 1'b1) begin
      failures++;
      $display("FAIL rot_p0_last got motor=%b act=%b exp 10/1", motorOut, activePlayer);
    end
    repeat (14) @(negedge clk);
  endtask
  task automatic test_held();
    int on = 0;
    int rises = 0;
    logic prev = 1'b0;
    do_reset();
    reqStrobe = 2'b01;
    reqPulses = 6'o01;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 20) reqStrobe = '0;
      if (motorOut[0]) on++;
      if (motorOut[0] && !prev) rises++;
      prev = motorOut[0];
    end
    checks++;
    if (rises != 1 || on != 4) begin
      failures++;
      $display("FAIL held_one_pulse got rises=%0d on=%0d exp 1/4", rises, on);
    end
    checks++;
    if (busy !== 1'b0 || pending !== 2'b00) begin
      failures++;
      $display("FAIL held_end got busy=%b pend=%b exp 0/00", busy, pending);
    end
    reqStrobe = 2'b10;
    reqPulses = 6'o00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) reqStrobe = '0;
      checks++;
      if (pending !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL count0 k=%0d got pend=%b busy=%b exp 00/0", k, pending, busy);
      end
    end
  endtask
  task automatic test_restrobe();
    logic [1:0] em;
    int on = 0;
    int rises = 0;
    logic prev = 1'b0;
    do_reset();
    reqStrobe = 2'b01;
    reqPulses = 6'o01;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4) reqStrobe = '0;
      if (k == 3) begin
        reqStrobe = 2'b01;
        reqPulses = 6'o03;
      end
      em = ((k >= 2 && k <= 5) || (k >= 9 && k - 9 < 21 && (k - 9) % 7 < 4)) ? 2'b01 : 2'b00;
      checks++;
      if (motorOut !== em || busy !== (k >= 2 && k <= 29)) begin
        failures++;
        $display("FAIL replay k=%0d got motor=%b busy=%b exp motor=%b", k, motorOut, busy, em);
      end
    end
    do_reset();
    reqStrobe = 2'b10;
    reqPulses = 6'o10;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4 || k == 6) reqStrobe = '0;
      if (k == 3) begin
        reqStrobe = 2'b01;
        reqPulses = 6'o02;
      end
      if (k == 5) begin
        reqStrobe = 2'b01;
        reqPulses = 6'o05;
      end
      if (motorOut[0]) on++;
      if (motorOut[0] && !prev) rises++;
      prev = motorOut[0];
    end
    checks++;
    if (rises != 5 || on != 20) begin
      failures++;
      $display("FAIL latest_wins got rises=%0d on=%0d exp 5/20", rises, on);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL latest_wins_idle got busy=%b exp=0", busy);
    end
  endtask
  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    reqStrobe = 2'b01;
    reqPulses = 6'o03;
    @(negedge clk);
    reqStrobe = '0;
    @(negedge clk);
    reqStrobe = 2'b10;
    reqPulses = 6'o10;
    @(negedge clk);
    reqStrobe = '0;
    @(negedge clk);
    checks++;
    if (motorOut !== 2'b01 || pending !== 2'b10) begin
      failures++;
      $display("FAIL midrst_pre got motor=%b pend=%b exp 01/10", motorOut, pending);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (motorOut !== 2'b00 || busy !== 1'b0 || pending !== 2'b00) begin
      failures++;
      $display("FAIL midrst_async got motor=%b busy=%b pend=%b exp 00/0/00", motorOut, busy, pending);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (motorOut !== 2'b00 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_after got bad_cycles=%0d exp=0", bad);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_both();
    test_rotation();
    test_held();
    test_restrobe();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
